xbar_slave_arbiter: RTL and testbench

Shares one crossbar slave port between `N_MASTERS` master ports using round-robin arbitration, and routes in-order read responses back to the issuing master. One instance sits in front of each slave in the crossbar. It carries the standard crossbar request/acknowledge/response signal set on both sides, with widths taken from the shared interface package. An internal ID FIFO tracks outstanding reads so that responses reach the correct master.

---
 rtl/interface_connection.sv | 23 ++
 rtl/xbar_id_fifo.sv | 70 +++++++
 rtl/xbar_slave_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_xbar_slave_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interface_connection.sv
// Shared crossbar interface package: bus widths, command and arbiter state encodings.
package interface_connection;

  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int MAX_MASTERS = 16;

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } cmd_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Index width for a master ID; a single master still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xbar_id_fifo.sv
// In-order ID FIFO holding the master index of each outstanding read.
// Same-cycle push and pop are both performed.
module xbar_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_id,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [PW:0]                 cnt_q, cnt_d;
  logic                        do_push;
  logic                        do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state for storage, pointers and occupancy; pointers wrap on power-of-two depth.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Round-robin arbiter sharing one crossbar slave port, with in-order read response routing.
// Optional XBAR_ARB_PERF_EN adds per-master 16-bit grant counters on port grant_cnt.
module xbar_slave_arbiter
  import interface_connection::*;
#(
  parameter int N_MASTERS  = 4,
  parameter int RD_DEPTH   = 4,
  parameter int ADDR_WIDTH = interface_connection::ADDR_WIDTH,
  parameter int DATA_WIDTH = interface_connection::DATA_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_MASTERS-1:0]                 m_req,
  input  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr,
  input  logic [N_MASTERS-1:0]                 m_cmd,
  input  logic [N_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata,
  output logic [N_MASTERS-1:0]                 m_ack,
  output logic [DATA_WIDTH-1:0]                m_rdata,
  output logic [N_MASTERS-1:0]                 m_resp,
  output logic                                 s_req,
  output logic [ADDR_WIDTH-1:0]                s_addr,
  output logic                                 s_cmd,
  output logic [DATA_WIDTH-1:0]                s_wdata,
  input  logic                                 s_ack,
  input  logic [DATA_WIDTH-1:0]                s_rdata,
  input  logic                                 s_resp,
  output logic                                 err
`ifdef XBAR_ARB_PERF_EN
  ,
  output logic [N_MASTERS-1:0][15:0]           grant_cnt
`endif
);

  localparam int IDW = id_width(N_MASTERS);

  arb_state_e               state_q, state_d;
  logic [IDW-1:0]           gnt_id_q, gnt_id_d;
  logic [IDW-1:0]           rr_ptr_q, rr_ptr_d;
  logic                     s_req_q, s_req_d;
  logic [ADDR_WIDTH-1:0]    s_addr_q, s_addr_d;
  logic                     s_cmd_q, s_cmd_d;
  logic [DATA_WIDTH-1:0]    s_wdata_q, s_wdata_d;
  logic                     err_q, err_d;

  logic [N_MASTERS-1:0]     elig;
  logic                     found;
  logic [IDW-1:0]           win;
  logic [IDW-1:0]           cand;
  logic                     xfer;
  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [IDW-1:0]           fifo_head;

  assign xfer      = (state_q == BUSY) & s_ack;
  assign fifo_push = xfer & (s_cmd_q == CMD_RD);
  assign fifo_pop  = s_resp & ~fifo_empty;

  assign m_ack   = (xfer & ~rst)     ? (N_MASTERS'(1'b1) << gnt_id_q)  : '0;
  assign m_resp  = (fifo_pop & ~rst) ? (N_MASTERS'(1'b1) << fifo_head) : '0;
  assign m_rdata = s_rdata;
  assign s_req   = s_req_q;
  assign s_addr  = s_addr_q;
  assign s_cmd   = s_cmd_q;
  assign s_wdata = s_wdata_q;
  assign err     = err_q;

  // Reads are ineligible while the ID FIFO is full; scan starts at rr_ptr and wraps.
  always_comb begin
    elig  = '0;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      elig[i] = m_req[i] & ~((m_cmd[i] == CMD_RD) & fifo_full);
    end
    for (int k = 0; k < N_MASTERS; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % N_MASTERS);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end else begin
        found = found;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    rr_ptr_d  = rr_ptr_q;
    s_req_d   = s_req_q;
    s_addr_d  = s_addr_q;
    s_cmd_d   = s_cmd_q;
    s_wdata_d = s_wdata_q;
    err_d     = err_q | (s_resp & fifo_empty);
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = BUSY;
          gnt_id_d  = win;
          s_req_d   = 1'b1;
          s_addr_d  = m_addr[win];
          s_cmd_d   = m_cmd[win];
          s_wdata_d = m_wdata[win];
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (s_ack) begin
          state_d   = IDLE;
          rr_ptr_d  = (gnt_id_q == IDW'(N_MASTERS - 1)) ? '0 : gnt_id_q + IDW'(1);
          s_req_d   = 1'b0;
          s_addr_d  = '0;
          s_cmd_d   = 1'b0;
          s_wdata_d = '0;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d   = IDLE;
        s_req_d   = 1'b0;
        s_addr_d  = '0;
        s_cmd_d   = 1'b0;
        s_wdata_d = '0;
      end
    endcase
  end

`ifdef XBAR_ARB_PERF_EN
  logic [N_MASTERS-1:0][15:0] grant_cnt_q, grant_cnt_d;
  assign grant_cnt = grant_cnt_q;

  // Wrapping per-master grant counters.
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      if (m_ack[i]) begin
        grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
      end else begin
        grant_cnt_d[i] = grant_cnt_q[i];
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_id_q  <= '0;
      rr_ptr_q  <= '0;
      s_req_q   <= 1'b0;
      s_addr_q  <= '0;
      s_cmd_q   <= 1'b0;
      s_wdata_q <= '0;
      err_q     <= 1'b0;
`ifdef XBAR_ARB_PERF_EN
      grant_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      rr_ptr_q  <= rr_ptr_d;
      s_req_q   <= s_req_d;
      s_addr_q  <= s_addr_d;
      s_cmd_q   <= s_cmd_d;
      s_wdata_q <= s_wdata_d;
      err_q     <= err_d;
`ifdef XBAR_ARB_PERF_EN
      grant_cnt_q <= grant_cnt_d;
`endif
    end
  end

  xbar_id_fifo #(
    .WIDTH (IDW),
    .DEPTH (RD_DEPTH)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .push_id (gnt_id_q),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Randomized and directed bench for xbar_slave_arbiter against a transaction-level reference model.
module tb_xbar_slave_arbiter;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         m_req;
  logic [N-1:0][AW-1:0] m_addr;
  logic [N-1:0]         m_cmd;
  logic [N-1:0][DW-1:0] m_wdata;
  logic [N-1:0]         m_ack;
  logic [DW-1:0]        m_rdata;
  logic [N-1:0]         m_resp;
  logic                 s_req;
  logic [AW-1:0]        s_addr;
  logic                 s_cmd;
  logic [DW-1:0]        s_wdata;
  logic                 s_ack;
  logic [DW-1:0]        s_rdata;
  logic                 s_resp;
  logic                 err;
`ifdef XBAR_ARB_PERF_EN
  logic [N-1:0][15:0]   grant_cnt;
`endif

  always #5 clk = ~clk;

  xbar_slave_arbiter #(
    .N_MASTERS (N),
    .RD_DEPTH  (D),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_req   (m_req),
    .m_addr  (m_addr),
    .m_cmd   (m_cmd),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_rdata (m_rdata),
    .m_resp  (m_resp),
    .s_req   (s_req),
    .s_addr  (s_addr),
    .s_cmd   (s_cmd),
    .s_wdata (s_wdata),
    .s_ack   (s_ack),
    .s_rdata (s_rdata),
    .s_resp  (s_resp),
    .err     (err)
`ifdef XBAR_ARB_PERF_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: one transfer in flight, outstanding read owners in a queue.
  bit mb_busy  = 1'b0;
  int mb_owner = 0;
  int mb_ptr   = 0;
  int mb_q[$];
  bit mb_err   = 1'b0;
  int gcnt[N];
  int acked    = -1;
  int slv_pend = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare();
    logic [N-1:0] ack_e;
    logic [N-1:0] resp_e;
    ack_e  = '0;
    resp_e = '0;
    if (mb_busy && s_ack && !rst) ack_e[mb_owner] = 1'b1;
    if (s_resp && mb_q.size() > 0 && !rst) resp_e[mb_q[0]] = 1'b1;
    check("m_ack",   64'(m_ack),   64'(ack_e));
    check("m_resp",  64'(m_resp),  64'(resp_e));
    check("m_rdata", 64'(m_rdata), 64'(s_rdata));
    check("s_req",   64'(s_req),   64'(mb_busy));
    check("s_addr",  64'(s_addr),  mb_busy ? 64'(m_addr[mb_owner])  : 64'd0);
    check("s_cmd",   64'(s_cmd),   mb_busy ? 64'(m_cmd[mb_owner])   : 64'd0);
    check("s_wdata", 64'(s_wdata), mb_busy ? 64'(m_wdata[mb_owner]) : 64'd0);
    check("err",     64'(err),     64'(mb_err));
`ifdef XBAR_ARB_PERF_EN
    for (int i = 0; i < N; i++) check("grant_cnt", 64'(grant_cnt[i]), 64'(gcnt[i]));
`endif
  endtask

  task automatic update();
    bit full;
    int who;
    acked = -1;
    if (s_resp && slv_pend > 0) slv_pend--;
    if (rst) begin
      mb_busy = 1'b0;
      mb_ptr  = 0;
      mb_q.delete();
      mb_err  = 1'b0;
      for (int i = 0; i < N; i++) gcnt[i] = 0;
    end else begin
      full = (mb_q.size() >= D);
      if (s_resp) begin
        if (mb_q.size() > 0) void'(mb_q.pop_front());
        else mb_err = 1'b1;
      end
      if (mb_busy) begin
        if (s_ack) begin
          acked = mb_owner;
          if (m_cmd[mb_owner] == 1'b0) begin
            mb_q.push_back(mb_owner);
            slv_pend++;
          end
          gcnt[mb_owner] = (gcnt[mb_owner] + 1) % 65536;
          mb_ptr  = (mb_owner + 1) % N;
          mb_busy = 1'b0;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          who = (mb_ptr + k) % N;
          if (m_req[who] && !(m_cmd[who] == 1'b0 && full)) begin
            mb_busy  = 1'b1;
            mb_owner = who;
            break;
          end
        end
      end
    end
  endtask

  // Inputs are applied at the falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    #1;
    compare();
    update();
    @(negedge clk);
  endtask

  task automatic drive_rand(input int p_ack, input int p_resp);
    for (int i = 0; i < N; i++) begin
      if (acked == i || !m_req[i]) begin
        if ($urandom_range(0, 99) < 60) begin
          m_req[i]   = 1'b1;
          m_cmd[i]   = 1'($urandom_range(0, 1));
          m_addr[i]  = $urandom;
          m_wdata[i] = $urandom;
        end else begin
          m_req[i] = 1'b0;
        end
      end
    end
    s_ack   = ($urandom_range(0, 99) < p_ack);
    s_resp  = (slv_pend > 0) && ($urandom_range(0, 99) < p_resp);
    s_rdata = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    slv_pend = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd, wr, lat;
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    rst = 1'b1; m_req = '0; m_addr = '0; m_cmd = '0; m_wdata = '0;
    s_ack = 1'b0; s_rdata = '0; s_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    rst = 1'b0;
    step();

    // Single read from master 2, 0-wait slave, response three cycles after ack.
    m_req = 4'b0100; m_cmd = 4'b0000; m_addr[2] = 32'h100; s_ack = 1'b1;
    step();
    #1 check("t1_ack", 64'(m_ack), 64'h4);
    step();
    m_req = '0; s_ack = 1'b0;
    step();
    step();
    s_resp = 1'b1; s_rdata = 32'hDEADBEEF;
    #1 check("t1_resp", 64'(m_resp), 64'h4);
    check("t1_rdata", 64'(m_rdata), 64'hDEADBEEF);
    step();
    s_resp = 1'b0;

    // Four masters writing back to back: one ack per master every 8 cycles.
    begin
      int cnt[N];
      for (int i = 0; i < N; i++) cnt[i] = 0;
      m_req = 4'b1111; m_cmd = 4'b1111; s_ack = 1'b1;
      for (int c = 0; c < 32; c++) begin
        step();
        if (acked >= 0) begin
          cnt[acked]++;
          m_wdata[acked] = $urandom;
        end
      end
      for (int i = 0; i < N; i++) check("t2_acks", 64'(cnt[i]), 64'd4);
    end
    m_req = '0;
    do_reset();

    // Reads from masters 1 and 3 return to their issuers in order.
    m_req = 4'b1010; m_cmd = 4'b0000; s_ack = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (acked >= 0) m_req[acked] = 1'b0;
    end
    s_ack = 1'b0; s_resp = 1'b1; s_rdata = 32'hA;
    #1 check("t3_resp1", 64'(m_resp), 64'h2);
    step();
    s_rdata = 32'hB;
    #1 check("t3_resp3", 64'(m_resp), 64'h8);
    step();
    s_resp = 1'b0;

    // Five reads from master 0 with no responses: the fifth waits, a write still passes.
    m_req = 4'b0001; m_cmd = 4'b0000; s_ack = 1'b1; rd = 0; wr = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 12) begin
        m_req[1] = 1'b1; m_cmd[1] = 1'b1; m_wdata[1] = $urandom;
      end
      step();
      if (acked == 0) begin rd++; m_addr[0] = $urandom; end
      if (acked == 1) begin wr++; m_req[1] = 1'b0; end
    end
    check("t4_reads", 64'(rd), 64'd4);
    check("t4_write", 64'(wr), 64'd1);
    s_resp = 1'b1; s_rdata = $urandom;
    step();
    s_resp = 1'b0; lat = -1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (acked == 0 && lat < 0) begin lat = c; m_req[0] = 1'b0; end
    end
    check("t4_unblock", 64'(lat), 64'd2);

    // Drain, then a spurious response sets a sticky err that only reset clears.
    s_ack = 1'b0; s_resp = 1'b1;
    for (int c = 0; c < 5; c++) begin
      s_rdata = $urandom;
      step();
    end
    s_resp = 1'b0;
    #1 check("t5_err_set", 64'(err), 64'd1);
    step(); step(); step();
    #1 check("t5_err_hold", 64'(err), 64'd1);
    do_reset();
    #1 check("t5_err_clr", 64'(err), 64'd0);

    // Reset while BUSY without ack; an earlier read's late response flags err.
    m_req = 4'b0010; m_cmd = 4'b0000; s_ack = 1'b1;
    step(); step();
    m_req = 4'b0100; m_cmd = 4'b1111; s_ack = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; m_req = '0;
    #1 check("t6_sreq", 64'(s_req), 64'd0);
`ifdef XBAR_ARB_PERF_EN
    for (int i = 0; i < N; i++) check("t6_gcnt", 64'(grant_cnt[i]), 64'd0);
`endif
    s_resp = 1'b1;
    step();
    s_resp = 1'b0;
    #1 check("t6_late_err", 64'(err), 64'd1);
    m_req = 4'b1001; s_ack = 1'b1;
    step(); step();
    check("t6_rrptr", 64'(acked), 64'd0);
    m_req = '0;
    step(); step();
    do_reset();

    // Randomized traffic, then a response-starved phase that keeps the FIFO full.
    for (int c = 0; c < 3000; c++) begin
      drive_rand(50, 40);
      step();
    end
    for (int c = 0; c < 1500; c++) begin
      drive_rand(70, 5);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
